// File: rtl/mipi_csi_rx_packet_decoder_4lane.sv
// Purpose: CSI-2 4-lane packet decoder. Decodes DI/WC, filters by VC and RAW data type, strips header and CRC, realigns payload to 8 bytes per beat.
// Latency: output beat j is valid the cycle after input beat j+1 (header is input beat 0); short-packet and truncation pulses appear one cycle after their cause.
// Backpressure: none. The aligner cannot be stalled, so every valid payload beat is emitted as it arrives.
//
// Ports:
//   clk_i, reset_n_i         byte clock, async active-low reset
//   data_valid_i, data_i     aligner beats; lane n = data_i[16n+15:16n], low byte first in time
//   data_valid_o, data_o     payload beats; lane n = {payload[8j+4+n], payload[8j+n]}
//   packet_type_o            DT[2:0] of the last accepted long packet
//   word_count_o             WC of the last accepted long packet
//   frame_start_o            one-cycle pulse on an FS short packet
//   frame_end_o              one-cycle pulse on an FE short packet
//   err_truncated_o          one-cycle pulse when the burst ends before WC bytes arrived
module mipi_csi_rx_packet_decoder_4lane #(
    parameter logic [1:0] VC_ID     = 2'd0,
    parameter bit         FILTER_VC = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [63:0] data_i,
    output logic        data_valid_o,
    output logic [63:0] data_o,
    output logic [2:0]  packet_type_o,
    output logic [15:0] word_count_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        err_truncated_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PAYLOAD  = 2'd1,
        ST_WAIT_EOT = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] hi_reg;      // high bytes of the previous beat, lane n at [8n+7:8n]
    logic [15:0] remaining;   // payload bytes still owed by the current long packet

    // Lane byte views of the incoming beat
    logic [31:0] lo_bytes;
    logic [31:0] hi_bytes;
    logic [63:0] beat_dat;

    always_comb begin
        lo_bytes = '0;
        hi_bytes = '0;
        beat_dat = '0;
        for (int n = 0; n < 4; n++) begin
            lo_bytes[8*n +: 8]  = data_i[16*n +: 8];
            hi_bytes[8*n +: 8]  = data_i[16*n+8 +: 8];
            // Payload bytes 8j..8j+3 were held from the previous beat; 8j+4..8j+7 are this beat's low bytes
            beat_dat[16*n +: 16] = {data_i[16*n +: 8], hi_reg[8*n +: 8]};
        end
    end

    // Header fields, only meaningful on the first beat of a burst
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic        vc_ok;
    logic        dt_fs;
    logic        dt_fe;
    logic        dt_raw_long;
    logic        last_beat;

    assign hdr_di      = lo_bytes[7:0];
    assign hdr_wc      = {lo_bytes[23:16], lo_bytes[15:8]};
    assign hdr_vc      = hdr_di[7:6];
    assign hdr_dt      = hdr_di[5:0];
    assign vc_ok       = (FILTER_VC == 1'b0) || (hdr_vc == VC_ID);
    assign dt_fs       = vc_ok && (hdr_dt == 6'h00);
    assign dt_fe       = vc_ok && (hdr_dt == 6'h01);
    assign dt_raw_long = vc_ok && (hdr_wc != 16'd0) &&
                         ((hdr_dt == 6'h2B) || (hdr_dt == 6'h2C) || (hdr_dt == 6'h2D));
    assign last_beat   = (remaining <= 16'd8);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. IDLE is only entered while data_valid_i is low (or from
    // reset), so a valid beat seen in IDLE is always the rising edge of a burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid_i) begin
                    state_d = dt_raw_long ? ST_PAYLOAD : ST_WAIT_EOT;
                end
            end
            ST_PAYLOAD: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end else if (last_beat) begin
                    state_d = ST_WAIT_EOT;
                end
            end
            ST_WAIT_EOT: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: control strobes for the registered datapath
    logic hdr_long;
    logic hdr_fs;
    logic hdr_fe;
    logic beat_take;
    logic trunc;

    always_comb begin
        hdr_long  = 1'b0;
        hdr_fs    = 1'b0;
        hdr_fe    = 1'b0;
        beat_take = 1'b0;
        trunc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hdr_long = data_valid_i && dt_raw_long;
                hdr_fs   = data_valid_i && dt_fs;
                hdr_fe   = data_valid_i && dt_fe;
            end
            ST_PAYLOAD: begin
                beat_take = data_valid_i;
                trunc     = !data_valid_i;
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hi_reg          <= '0;
            remaining       <= '0;
            data_valid_o    <= 1'b0;
            data_o          <= '0;
            packet_type_o   <= '0;
            word_count_o    <= '0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            err_truncated_o <= 1'b0;
        end else begin
            data_valid_o    <= beat_take;
            frame_start_o   <= hdr_fs;
            frame_end_o     <= hdr_fe;
            err_truncated_o <= trunc;

            if (hdr_long) begin
                // Type/WC change here, a full cycle before data_valid_o can rise,
                // so the depacker sees them settled while its valid is still low.
                packet_type_o <= hdr_dt[2:0];
                word_count_o  <= hdr_wc;
                hi_reg        <= hi_bytes;
                remaining     <= hdr_wc;
            end else if (beat_take) begin
                data_o    <= beat_dat;
                hi_reg    <= hi_bytes;
                remaining <= (remaining > 16'd8) ? (remaining - 16'd8) : 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_4lane.sv
// Purpose: self-checking bench for the CSI-2 4-lane packet decoder, VC-filtered and any-VC instances side by side.
// Latency: expectations are placed on the cycle the decoder's latency rules give.
// Backpressure: none; stimulus is a free-running stream of packet bursts.
module tb_mipi_csi_rx_packet_decoder_4lane;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        data_valid_i;
    logic [63:0] data_i;

    logic        vld_a, vld_b;
    logic [63:0] dat_a, dat_b;
    logic [2:0]  type_a, type_b;
    logic [15:0] wc_a, wc_b;
    logic        fs_a, fs_b, fe_a, fe_b, err_a, err_b;

    always #5 clk_i = ~clk_i;

    // Instance 0 filters on VC 0, instance 1 accepts any VC
    mipi_csi_rx_packet_decoder_4lane #(.VC_ID(2'd0), .FILTER_VC(1'b1)) u_dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .data_valid_o    (vld_a),
        .data_o          (dat_a),
        .packet_type_o   (type_a),
        .word_count_o    (wc_a),
        .frame_start_o   (fs_a),
        .frame_end_o     (fe_a),
        .err_truncated_o (err_a)
    );

    mipi_csi_rx_packet_decoder_4lane #(.VC_ID(2'd0), .FILTER_VC(1'b0)) u_dut_any (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .data_valid_o    (vld_b),
        .data_o          (dat_b),
        .packet_type_o   (type_b),
        .word_count_o    (wc_b),
        .frame_start_o   (fs_b),
        .frame_end_o     (fe_b),
        .err_truncated_o (err_b)
    );

    logic [1:0]  o_vld, o_fs, o_fe, o_err;
    logic [63:0] o_dat  [2];
    logic [2:0]  o_type [2];
    logic [15:0] o_wc   [2];

    assign o_vld     = {vld_b, vld_a};
    assign o_fs      = {fs_b, fs_a};
    assign o_fe      = {fe_b, fe_a};
    assign o_err     = {err_b, err_a};
    assign o_dat[0]  = dat_a;
    assign o_dat[1]  = dat_b;
    assign o_type[0] = type_a;
    assign o_type[1] = type_b;
    assign o_wc[0]   = wc_a;
    assign o_wc[1]   = wc_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte stream of the current burst: header bytes 0..3, payload from byte 4
    logic [7:0]  strm [0:66199];
    logic [2:0]  exp_type [2];
    logic [15:0] exp_wc   [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stream byte k sits in beat k/8: bytes 0..3 on the low byte of lanes 0..3, bytes 4..7 on the high bytes
    function automatic logic [63:0] beat_of(input int b);
        logic [63:0] d;
        d = '0;
        for (int n = 0; n < 4; n++) begin
            d[16*n +: 8]   = strm[8*b + n];
            d[16*n+8 +: 8] = strm[8*b + 4 + n];
        end
        return d;
    endfunction

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s vld%0d", tag, i), 64'(o_vld[i]), 64'd0);
            check($sformatf("%s dat%0d", tag, i), o_dat[i], 64'd0);
            check($sformatf("%s type%0d", tag, i), 64'(o_type[i]), 64'd0);
            check($sformatf("%s wc%0d", tag, i), 64'(o_wc[i]), 64'd0);
            check($sformatf("%s fs%0d", tag, i), 64'(o_fs[i]), 64'd0);
            check($sformatf("%s fe%0d", tag, i), 64'(o_fe[i]), 64'd0);
            check($sformatf("%s err%0d", tag, i), 64'(o_err[i]), 64'd0);
        end
    endtask

    // Sends one burst of nbeats beats followed by gap idle cycles and checks
    // every cycle against the packet rules. rst_at >= 0 aborts with a reset
    // after input beat rst_at has been sampled.
    task automatic run_pkt(input logic [7:0] di, input logic [15:0] wc, input int nbeats,
                           input int gap, input bit idx, input int rst_at);
        bit          fs_acc   [2];
        bit          fe_acc   [2];
        bit          long_acc [2];
        bit          ok;
        bit          ev;
        int          nlen, nout, npay, j, bi;
        logic [63:0] ed, em;
        nlen = nbeats * 8 + 8;
        for (int k = 0; k < nlen; k++) strm[k] = 8'($urandom);
        strm[0] = di;
        strm[1] = wc[7:0];
        strm[2] = wc[15:8];
        if (idx) begin
            for (int k = 0; k < int'(wc) && (4 + k) < nlen; k++) strm[4 + k] = 8'(k);
        end
        nout = (int'(wc) + 7) / 8;
        npay = nbeats - 1;
        for (int i = 0; i < 2; i++) begin
            ok          = (i == 1) || (di[7:6] == 2'd0);
            fs_acc[i]   = ok && (di[5:0] == 6'h00);
            fe_acc[i]   = ok && (di[5:0] == 6'h01);
            long_acc[i] = ok && (wc != 16'd0) &&
                          (di[5:0] == 6'h2B || di[5:0] == 6'h2C || di[5:0] == 6'h2D);
        end
        for (int c = 0; c < nbeats + gap; c++) begin
            data_valid_i = (c < nbeats);
            data_i       = (c < nbeats) ? beat_of(c) : {$urandom, $urandom};
            @(posedge clk_i);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (c == 0 && long_acc[i]) begin
                    exp_type[i] = di[2:0];
                    exp_wc[i]   = wc;
                end
                ev = long_acc[i] && c >= 1 && c <= npay && c <= nout;
                check($sformatf("vld%0d c%0d", i, c), 64'(o_vld[i]), 64'(ev));
                check($sformatf("fs%0d c%0d", i, c), 64'(o_fs[i]), 64'(fs_acc[i] && c == 0));
                check($sformatf("fe%0d c%0d", i, c), 64'(o_fe[i]), 64'(fe_acc[i] && c == 0));
                check($sformatf("err%0d c%0d", i, c), 64'(o_err[i]),
                      64'(long_acc[i] && npay < nout && c == npay + 1));
                check($sformatf("type%0d c%0d", i, c), 64'(o_type[i]), 64'(exp_type[i]));
                check($sformatf("wc%0d c%0d", i, c), 64'(o_wc[i]), 64'(exp_wc[i]));
                if (ev) begin
                    j  = c - 1;
                    ed = '0;
                    em = '0;
                    for (int n = 0; n < 4; n++) begin
                        bi = 8 * j + n;
                        if (bi < int'(wc)) begin
                            ed[16*n +: 8] = strm[4 + bi];
                            em[16*n +: 8] = 8'hFF;
                        end
                        bi = 8 * j + 4 + n;
                        if (bi < int'(wc)) begin
                            ed[16*n+8 +: 8] = strm[4 + bi];
                            em[16*n+8 +: 8] = 8'hFF;
                        end
                    end
                    check($sformatf("dat%0d b%0d", i, j), o_dat[i] & em, ed);
                end
            end
            if (c == rst_at) begin
                @(negedge clk_i);
                reset_n_i = 1'b0;
                #1;
                check_all_zero("midrst");
                for (int i = 0; i < 2; i++) begin
                    exp_type[i] = 3'd0;
                    exp_wc[i]   = 16'd0;
                end
                data_valid_i = 1'b0;
                repeat (2) @(posedge clk_i);
                @(negedge clk_i);
                reset_n_i = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        logic [5:0]  dt;
        logic [1:0]  vc;
        logic [15:0] wc;
        int          kind, nb, nn;

        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        for (int i = 0; i < 2; i++) begin
            exp_type[i] = 3'd0;
            exp_wc[i]   = 16'd0;
        end
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // Directed packets
        run_pkt(8'h00, 16'h0000, 1, 2, 1'b0, -1);       // FS
        run_pkt(8'h01, 16'h0000, 1, 2, 1'b0, -1);       // FE
        run_pkt(8'h2B, 16'd40, 6, 2, 1'b1, -1);         // RAW10, 5 output beats
        run_pkt(8'h2C, 16'd12, 4, 2, 1'b1, -1);         // RAW12 with CRC/trail beats
        run_pkt(8'h6B, 16'd40, 6, 2, 1'b1, -1);         // VC1: filtered vs accepted
        run_pkt(8'h2D, 16'd64, 3, 2, 1'b1, -1);         // RAW14 truncated
        run_pkt(8'h2B, 16'd40, 6, 2, 1'b1, -1);         // recovers afterwards
        run_pkt(8'h2B, 16'd0, 2, 2, 1'b0, -1);          // WC=0 ignored
        run_pkt(8'h2D, 16'd64, 9, 2, 1'b1, 2);          // reset mid-payload
        run_pkt(8'h2B, 16'd40, 6, 2, 1'b1, -1);         // decodes after reset
        run_pkt(8'h2C, 16'hFFFF, 8194, 2, 1'b0, -1);    // max WC, 8192 beats
        run_pkt(8'h2B, 16'd9, 3, 1, 1'b1, -1);          // WC just past one beat

        // Randomized packets
        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 9);
            vc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            wc   = 16'($urandom_range(1, 160));
            nn   = (int'(wc) + 7) / 8;
            dt   = 6'h2B + 6'($urandom_range(0, 2));
            nb   = nn + 1 + $urandom_range(0, 2);
            case (kind)
                0: begin dt = 6'h00; wc = 16'($urandom); nb = $urandom_range(1, 2); end
                1: begin dt = 6'h01; wc = 16'($urandom); nb = $urandom_range(1, 2); end
                7: begin
                    do dt = 6'($urandom_range(2, 63));
                    while (dt == 6'h2B || dt == 6'h2C || dt == 6'h2D);
                    nb = $urandom_range(1, 4);
                end
                8: begin wc = 16'd0; nb = $urandom_range(1, 3); end
                9: nb = $urandom_range(1, nn);
                default: ;
            endcase
            run_pkt({vc, dt}, wc, nb, $urandom_range(1, 3), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
